// File: rtl/adder_sched_pkg.sv
// Shared types and sizing helpers for the two-requester adder scheduler.
package adder_sched_pkg;

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_GAP = 1'b1
    } st_e;

    localparam int ID_W = 1;

    // Width needed to count 0..burst_len-1 (never narrower than one bit).
    function automatic int burst_cnt_w(input int unsigned burst_len);
        return (burst_len > 32'd1) ? $clog2(burst_len) : 1;
    endfunction

    function automatic int gap_cnt_w(input int unsigned gap_len);
        return (gap_len > 32'd1) ? $clog2(gap_len) : 1;
    endfunction

endpackage

// File: rtl/adder.sv
// Plain combinational N-bit adder; the carry-out is not produced.
module adder #(
    parameter int N = 28
) (
    input  logic [N-1:0] input1,
    input  logic [N-1:0] input2,
    output logic [N-1:0] sum
);

    assign sum = input1 + input2;

endmodule

// File: rtl/adder_req_scheduler.sv
// Round-robin sharing of one adder between two valid/ready requesters, with a
// registered result and burst/gap shaping of the accepted operation stream.
module adder_req_scheduler
    import adder_sched_pkg::*;
#(
    parameter int N         = 28,
    parameter int BURST_LEN = 20,
    parameter int GAP_LEN   = 7,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [N-1:0]     req0_a,
    input  logic [N-1:0]     req0_b,
    input  logic [N-1:0]     req1_a,
    input  logic [N-1:0]     req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [N-1:0]     rsp_sum,
    output logic [ID_W-1:0]  rsp_id,
    output logic             in_gap,
    output logic [CNT_W-1:0] ops_done
);

    localparam int BW = burst_cnt_w(BURST_LEN);
    localparam int GW = gap_cnt_w(GAP_LEN);

    st_e             state_r, state_nx_s;
    logic [BW-1:0]   burst_cnt_r, burst_cnt_nx_s;
    logic [GW-1:0]   gap_cnt_r, gap_cnt_nx_s;
    logic            in_gap_r;
    logic [ID_W-1:0] rr_ptr_r;
    logic            rsp_valid_r;
    logic [N-1:0]    rsp_sum_r;
    logic [ID_W-1:0] rsp_id_r;
    logic [CNT_W-1:0] ops_done_r;

    logic            grant_vld_s;
    logic [ID_W-1:0] grant_id_s;
    logic            can_accept_s;
    logic            accept_s;
    logic [1:0]      req_ready_s;
    logic [N-1:0]    op_a_s, op_b_s, sum_s;

    // Arbitration, accept decision and operand mux.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_id_s  = 1'b0;
        case (req_valid)
            2'b01: begin grant_vld_s = 1'b1; grant_id_s = 1'b0;     end
            2'b10: begin grant_vld_s = 1'b1; grant_id_s = 1'b1;     end
            2'b11: begin grant_vld_s = 1'b1; grant_id_s = rr_ptr_r; end
            default: begin grant_vld_s = 1'b0; grant_id_s = 1'b0;  end
        endcase
        // rst_n gates acceptance so nothing handshakes while reset is held.
        can_accept_s = rst_n && (state_r == ST_RUN) && (!rsp_valid_r || rsp_ready);
        accept_s     = grant_vld_s && can_accept_s;
        req_ready_s  = 2'b00;
        if (accept_s) begin
            req_ready_s[grant_id_s] = 1'b1;
        end else begin
            req_ready_s = 2'b00;
        end
        op_a_s = (grant_id_s == 1'b1) ? req1_a : req0_a;
        op_b_s = (grant_id_s == 1'b1) ? req1_b : req0_b;
    end

    adder #(.N(N)) u_adder (
        .input1 (op_a_s),
        .input2 (op_b_s),
        .sum    (sum_s)
    );

    // Burst/gap next-state and counter logic.
    always_comb begin
        state_nx_s     = state_r;
        burst_cnt_nx_s = burst_cnt_r;
        gap_cnt_nx_s   = gap_cnt_r;
        case (state_r)
            ST_RUN: begin
                if (accept_s) begin
                    if (burst_cnt_r == BW'(BURST_LEN - 1)) begin
                        burst_cnt_nx_s = {BW{1'b0}};
                        if (GAP_LEN > 0) begin
                            state_nx_s   = ST_GAP;
                            gap_cnt_nx_s = {GW{1'b0}};
                        end else begin
                            state_nx_s   = ST_RUN;
                        end
                    end else begin
                        burst_cnt_nx_s = burst_cnt_r + BW'(1);
                    end
                end else begin
                    burst_cnt_nx_s = burst_cnt_r;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GW'(GAP_LEN - 1)) begin
                    state_nx_s   = ST_RUN;
                    gap_cnt_nx_s = {GW{1'b0}};
                end else begin
                    gap_cnt_nx_s = gap_cnt_r + GW'(1);
                end
            end
            default: begin
                state_nx_s     = ST_RUN;
                burst_cnt_nx_s = {BW{1'b0}};
                gap_cnt_nx_s   = {GW{1'b0}};
            end
        endcase
    end

    // FSM state, counters and the registered in_gap flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_RUN;
            burst_cnt_r <= {BW{1'b0}};
            gap_cnt_r   <= {GW{1'b0}};
            in_gap_r    <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            burst_cnt_r <= burst_cnt_nx_s;
            gap_cnt_r   <= gap_cnt_nx_s;
            in_gap_r    <= (state_nx_s == ST_GAP);
        end
    end

    // Result register, round-robin pointer and statistics counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_sum_r   <= {N{1'b0}};
            rsp_id_r    <= {ID_W{1'b0}};
            rr_ptr_r    <= {ID_W{1'b0}};
            ops_done_r  <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            rsp_valid_r <= 1'b1;
            rsp_sum_r   <= sum_s;
            rsp_id_r    <= grant_id_s;
            rr_ptr_r    <= ~grant_id_s;
            ops_done_r  <= ops_done_r + CNT_W'(1);
        end else if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end else begin
            rsp_valid_r <= rsp_valid_r;
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_sum   = rsp_sum_r;
    assign rsp_id    = rsp_id_r;
    assign in_gap    = in_gap_r;
    assign ops_done  = ops_done_r;

endmodule

// File: tb/tb_adder_req_scheduler.sv
// Scoreboard bench for adder_req_scheduler: a transaction-level model predicts
// grants and gaps; expected results are queued and checked by a separate monitor.
module tb_adder_req_scheduler;

    localparam int N  = 28;
    localparam int BL = 20;
    localparam int GL = 7;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req_valid = 2'b00;
    logic [1:0]    req_ready;
    logic [N-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [N-1:0]  rsp_sum;
    logic [0:0]    rsp_id;
    logic          in_gap;
    logic [CW-1:0] ops_done;

    always #5 clk = ~clk;

    adder_req_scheduler #(.N(N), .BURST_LEN(BL), .GAP_LEN(GL), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
        .rsp_id(rsp_id), .in_gap(in_gap), .ops_done(ops_done)
    );

    typedef struct {
        logic [N-1:0] sum;
        logic         id;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state, in transaction terms.
    int            m_burst_ops;
    int            m_gap_left;
    bit            m_pending;
    bit            m_prio;
    logic [CW-1:0] m_ops;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_burst_ops = 0;
        m_gap_left  = 0;
        m_pending   = 1'b0;
        m_prio      = 1'b0;
        m_ops       = '0;
        exp_q.delete();
    endtask

    // One cycle of the model, evaluated at the falling edge with inputs stable.
    task automatic model_step();
        bit           allowed, any, g, was_gap;
        logic [1:0]   exp_ready;
        logic [N-1:0] a, b, s;
        rsp_t         r;
        allowed   = (m_gap_left == 0) && (!m_pending || rsp_ready);
        any       = (req_valid != 2'b00);
        g         = (req_valid == 2'b11) ? m_prio : req_valid[1];
        exp_ready = 2'b00;
        if (allowed && any) exp_ready[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("in_gap",    64'(in_gap),    64'(m_gap_left > 0));
        chk("rsp_valid", 64'(rsp_valid), 64'(m_pending));
        chk("ops_done",  64'(ops_done),  64'(m_ops));
        was_gap = (m_gap_left > 0);
        if (allowed && any) begin
            a = g ? req1_a : req0_a;
            b = g ? req1_b : req0_b;
            s = a + b;
            r.sum = s;
            r.id  = g;
            exp_q.push_back(r);
            m_ops       = m_ops + 32'd1;
            m_prio      = !g;
            m_pending   = 1'b1;
            m_burst_ops = m_burst_ops + 1;
            if (m_burst_ops == BL) begin
                m_burst_ops = 0;
                m_gap_left  = GL;
            end
        end else if (m_pending && rsp_ready) begin
            m_pending = 1'b0;
        end
        if (was_gap) m_gap_left = m_gap_left - 1;
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic rr);
        req_valid = v;
        rsp_ready = rr;
        tick();
    endtask

    task automatic rand_ops();
        req0_a = N'($urandom);
        req0_b = N'($urandom);
        req1_a = N'($urandom);
        req1_b = N'($urandom);
    endtask

    task automatic do_reset();
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_ops_done",  64'(ops_done),  64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_in_gap",    64'(in_gap),    64'd0);
        chk("rst_rsp_sum",   64'(rsp_sum),   64'd0);
        chk("rst_rsp_id",    64'(rsp_id),    64'd0);
        model_reset();
        req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: every presented result must match the oldest outstanding one.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got sum 0x%0h id %0d expected no result at %0t",
                         rsp_sum, rsp_id, $time);
            end else begin
                chk("rsp_sum", 64'(rsp_sum), 64'(exp_q[0].sum));
                chk("rsp_id",  64'(rsp_id),  64'(exp_q[0].id));
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        bit seen;
        int cyc;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Basic op and carry wrap.
        req0_a = 28'h0000001; req0_b = 28'h0000002;
        drive(2'b01, 1'b1);
        chk("t1_sum", 64'(rsp_sum), 64'h3);
        chk("t1_id",  64'(rsp_id),  64'd0);
        chk("t1_ops", 64'(ops_done), 64'd1);
        req1_a = 28'hFFFFFFF; req1_b = 28'h0000001;
        drive(2'b10, 1'b1);
        chk("t2_sum", 64'(rsp_sum), 64'h0);
        chk("t2_id",  64'(rsp_id),  64'd1);
        drive(2'b00, 1'b1);

        // Fairness with both requesters always valid.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            rand_ops();
            drive(2'b11, 1'b1);
            chk("t3_id", 64'(rsp_id), 64'(i % 2));
        end
        drive(2'b00, 1'b1);

        // Throttle: ten full burst+gap periods.
        do_reset();
        repeat (270) begin
            rand_ops();
            drive(2'b01, 1'b1);
        end
        chk("t4_ops", 64'(ops_done), 64'd200);

        // Backpressure and same-cycle consume+accept.
        do_reset();
        rand_ops();
        drive(2'b01, 1'b1);
        repeat (3) begin
            rand_ops();
            drive(2'b01, 1'b0);
        end
        chk("t5_stall_ops", 64'(ops_done), 64'd1);
        rand_ops();
        drive(2'b01, 1'b1);
        chk("t5_release_ops", 64'(ops_done), 64'd2);
        drive(2'b00, 1'b1);
        drive(2'b00, 1'b1);

        // Reset mid-burst, then a full burst before the first gap.
        do_reset();
        repeat (10) begin
            rand_ops();
            drive(2'b01, 1'b1);
        end
        chk("t6_pre_valid", 64'(rsp_valid), 64'd1);
        do_reset();
        seen = 1'b0;
        cyc  = 0;
        for (int i = 0; i < 40; i++) begin
            rand_ops();
            drive(2'b01, 1'b1);
            cyc = i + 1;
            if (in_gap) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t6_gap_seen", 64'(seen), 64'd1);
        chk("t6_gap_cycle", 64'(cyc), 64'd20);
        chk("t6_ops", 64'(ops_done), 64'd20);

        // Randomized traffic with random backpressure.
        do_reset();
        repeat (3000) begin
            rand_ops();
            drive(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
        end
        repeat (10) drive(2'b00, 1'b1);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
